// File: rtl/latch_bank_writer.sv
// latch_bank_writer
//   Write-side sequencer for a bank of NUM_LATCH level-sensitive D latches,
//   each DATA_W bits wide. A command (write one word, or clear all words) is
//   taken over a valid/ready handshake. The block then walks SETUP -> PULSE ->
//   HOLD so that lat_d is stable around the latch strobe, and pulses done
//   (with err on failure) when it returns to IDLE.
//
//   Optional build macro: LATCH_READBACK_CHECK_EN
//     When defined, input lat_q carries the latch outputs. It is compared on the
//     last HOLD cycle, and a mismatch raises err together with done.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   req_valid  command present
//   req_ready  command can be accepted (state IDLE)
//   req_clear  1 = clear all latches, 0 = write req_data to latch req_addr
//   req_addr   target latch for a write
//   req_data   write data
//   lat_q      latch outputs, word i at [i*DATA_W +: DATA_W] (readback build only)
//   lat_d      shared latch data bus
//   lat_en     one-hot latch enables
//   lat_rst    common latch reset strobe
//   busy       command in progress
//   done       one-cycle completion pulse
//   err        one-cycle failure pulse, coincident with done
module latch_bank_writer #(
  parameter int DATA_W    = 8,
  parameter int NUM_LATCH = 4,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_clear,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_data,
`ifdef LATCH_READBACK_CHECK_EN
  input  logic [NUM_LATCH*DATA_W-1:0] lat_q,
`endif
  output logic [DATA_W-1:0]           lat_d,
  output logic [NUM_LATCH-1:0]        lat_en,
  output logic                        lat_rst,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   clr_q;
  logic [NUM_LATCH-1:0]   mask_q;
  logic                   accept;
  logic                   addr_oor;
  logic [NUM_LATCH-1:0]   addr_mask;

`ifdef LATCH_READBACK_CHECK_EN
  // A write checks only the addressed word against lat_d; a clear checks that
  // every word reads back as zero.
  function automatic logic readback_bad(input logic [NUM_LATCH*DATA_W-1:0] q,
                                        input logic                        clr,
                                        input logic [NUM_LATCH-1:0]        mask,
                                        input logic [DATA_W-1:0]           d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_LATCH; i++) begin
      if (clr) begin
        if (q[i*DATA_W +: DATA_W] != '0) bad = 1'b1;
      end else if (mask[i] && (q[i*DATA_W +: DATA_W] != d)) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  // Extra top bit keeps the compare correct when 2**ADDR_W == NUM_LATCH.
  assign addr_oor  = ({1'b0, req_addr} >= (ADDR_W+1)'(NUM_LATCH));
  // An out-of-range address shifts the bit out, so the mask is simply zero.
  assign addr_mask = NUM_LATCH'(1) << req_addr;

  // Command capture: held for the whole command, needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      clr_q  <= req_clear;
      mask_q <= addr_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_d   <= '0;
      lat_en  <= '0;
      lat_rst <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_d <= req_clear ? '0 : req_data;
            if (!req_clear && addr_oor) begin
              // Nothing to strobe: report failure straight away.
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              state <= SETUP;
              cnt   <= 4'(SETUP_CYC - 1);
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= PULSE;
            cnt   <= 4'(PULSE_CYC - 1);
            if (clr_q) lat_rst <= 1'b1;
            else       lat_en  <= mask_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state   <= HOLD;
            cnt     <= 4'(HOLD_CYC - 1);
            lat_en  <= '0;
            lat_rst <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
            done  <= 1'b1;
`ifdef LATCH_READBACK_CHECK_EN
            err   <= readback_bad(lat_q, clr_q, mask_q, lat_d);
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
